// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and state encodings for the parametrised UART core.
//   OVERSAMPLE : ticks per serial bit period
//   MID_SAMPLE : tick (1-based) after a start-bit edge at which the start bit
//                is re-sampled; later bits are sampled OVERSAMPLE ticks apart
//   tx_state_t : transmitter FSM states
//   rx_state_t : receiver FSM states
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through receive FIFO: the head entry is always presented on
// head_o while valid_o is high.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i (dropped with overrun_o if full and no pop)
//   pop_i         : remove head when valid_o is high
//   head_o        : head entry
//   valid_o       : FIFO non-empty
//   count_o       : exact occupancy, updated the cycle after a push/pop
//   overrun_o     : one-cycle pulse, a push was dropped because FIFO was full
// Valid/ready: an entry leaves the FIFO in any cycle where valid_o && pop_i.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overrun_q;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop_i && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            overrun_q <= push_i && full && !do_pop;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_core_param.sv
// ----------------------------------------------------------------------------
// uart_core_param
// Parametrised UART transceiver with a shared 16x tick generator, TX/RX FSMs
// and a first-word-fall-through RX FIFO.
// Optional feature macro: UART_PARITY_EN adds one parity bit (sense from
// parity_odd) to both directions and enables parity_err.
//   clk, rst_n           : clock, asynchronous active-low reset
//   baud_div             : tick every baud_div+1 cycles, bit = 16 ticks
//   parity_odd           : 1 odd / 0 even parity
//   tx_data/valid/ready  : byte to send; accepted when tx_valid && tx_ready
//   txd                  : serial out, idle high
//   rxd                  : asynchronous serial in
//   rx_data/valid/ready  : FIFO head; popped when rx_valid && rx_ready
//   rx_count             : FIFO occupancy
//   frame_err            : pulse, stop bit sampled low (byte discarded)
//   parity_err           : pulse, parity mismatch (byte discarded)
//   overrun              : pulse, byte dropped because FIFO full
// Valid/ready: a transfer happens on every clock edge where valid && ready are
// both high; valid must not depend on ready.
// ----------------------------------------------------------------------------
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int DIV_W         = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DIV_W-1:0]                 baud_div,
    input  logic                             parity_odd,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             txd,
    input  logic                             rxd,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
    output logic                             frame_err,
    output logic                             parity_err,
    output logic                             overrun
);

    localparam int           BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS-1);
    localparam logic [3:0]   TICK_LAST = 4'(OVERSAMPLE-1);
    localparam logic [3:0]   TICK_MID  = 4'(MID_SAMPLE-1);
    localparam logic         STOP_LAST = 1'(STOP_BITS-1);

    // ---------------- tick generator ----------------
    // A new baud_div is only picked up on reload, so a change never
    // produces a runt tick period.
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;

    assign tick = (div_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt_q <= '0;
        else if (tick) div_cnt_q <= baud_div;
        else           div_cnt_q <= div_cnt_q - DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q;
    logic [3:0]           tx_tick_q;
    logic [BW-1:0]        tx_bit_q;
    logic                 tx_stop_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 txd_q;
    logic                 tx_par_q;
    logic                 tx_bit_end;
    logic                 tx_last_stop;
    logic                 tx_accept;

    assign tx_bit_end   = tick && (tx_tick_q == TICK_LAST);
    // Ready in the final cycle of the last stop bit so frames can abut.
    assign tx_last_stop = (tx_state_q == TX_STOP) && tx_bit_end && (tx_stop_q == STOP_LAST);
    assign tx_ready     = (tx_state_q == TX_IDLE) || tx_last_stop;
    assign tx_accept    = tx_valid && tx_ready;
    assign txd          = txd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_par_q   <= 1'b0;
        end else begin
            // 4-bit tick counter wraps to 0 at each bit boundary by itself.
            if (tick && (tx_state_q != TX_IDLE)) tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_accept) begin
                tx_state_q <= TX_START;
                tx_shift_q <= tx_data;
                tx_par_q   <= (^tx_data) ^ parity_odd;
                tx_tick_q  <= '0;
                txd_q      <= 1'b0;
            end else if (tx_bit_end) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                    end
                    TX_DATA: begin
                        tx_shift_q <= tx_shift_q >> 1;
                        txd_q      <= tx_shift_q[1];
                        tx_bit_q   <= tx_bit_q + BW'(1);
                        if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state_q <= TX_PARITY;
                            txd_q      <= tx_par_q;
`else
                            tx_state_q <= TX_STOP;
                            txd_q      <= 1'b1;
                            tx_stop_q  <= 1'b0;
`endif
                        end
                    end
                    TX_PARITY: begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end
                    TX_STOP: begin
                        if (tx_stop_q == STOP_LAST) tx_state_q <= TX_IDLE;
                        else                        tx_stop_q  <= 1'b1;
                    end
                    default: tx_state_q <= TX_IDLE;
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t            rx_state_q;
    logic [3:0]           rx_tick_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_fall;
    logic                 rx_bit_end;
    logic                 rx_stop_sample;
    logic                 rx_par_bad;
    logic                 rx_push;
    logic                 frame_err_q;
    logic                 parity_err_q;

    assign rx_fall        = rx_s3_q && !rx_s2_q;
    assign rx_bit_end     = tick && (rx_tick_q == TICK_LAST);
    assign rx_stop_sample = (rx_state_q == RX_STOP) && rx_bit_end;

`ifdef UART_PARITY_EN
    logic rx_par_q;
    // Data plus parity bit must XOR to parity_odd.
    assign rx_par_bad = (^rx_shift_q) ^ rx_par_q ^ parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd ^ tx_par_q;
    assign rx_par_bad = 1'b0;
`endif

    assign rx_push = rx_stop_sample && rx_s2_q && !rx_par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
`endif
        end else begin
            rx_s1_q      <= rxd;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            frame_err_q  <= rx_stop_sample && !rx_s2_q;
            parity_err_q <= rx_stop_sample && rx_s2_q && rx_par_bad;
            if (tick && (rx_state_q != RX_IDLE)) rx_tick_q <= rx_tick_q + 4'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_tick_q  <= '0;
                    end
                end
                RX_START: begin
                    // Re-sample mid start bit; restarting the counter here puts
                    // every later sample at a bit centre.
                    if (tick && (rx_tick_q == TICK_MID)) begin
                        rx_tick_q <= '0;
                        rx_bit_q  <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_q   <= rx_bit_q + BW'(1);
                        if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= RX_PARITY;
`else
                            rx_state_q <= RX_STOP;
`endif
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
`ifdef UART_PARITY_EN
                        rx_par_q <= rx_s2_q;
`endif
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (rx_push),
        .push_data_i (rx_shift_q),
        .pop_i       (rx_ready),
        .head_o      (rx_data),
        .valid_o     (rx_valid),
        .count_o     (rx_count),
        .overrun_o   (overrun)
    );

endmodule

// File: tb/tb_uart_core_param.sv
// ----------------------------------------------------------------------------
// tb_uart_core_param
// Directed bench for uart_core_param (8 data bits, 1 stop, depth 4,
// baud_div = 3, i.e. 64 clocks per bit). txd can be looped back to rxd or
// rxd can be bit-banged. Frames are started on tick-aligned cycles (every 4th
// cycle after reset release) so the TX bit boundaries are exact.
// ----------------------------------------------------------------------------
module tb_uart_core_param;

    localparam int DB      = 8;
    localparam int BD      = 3;
    localparam int BIT_CYC = 16 * (BD + 1);
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DB + PB + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] baud_div;
    logic        parity_odd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  rx_count;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic        loop_en;
    logic        rxd_drv;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_core_param #(
        .DATA_BITS     (8),
        .STOP_BITS     (1),
        .RX_FIFO_DEPTH (4),
        .DIV_W         (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    // Cycle index since reset release; ticks fall where cyc % (BD+1) == 0.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_fe = 0;
    int n_pe = 0;
    int n_ov = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  n_fe <= n_fe + 1;
            if (parity_err) n_pe <= n_pe + 1;
            if (overrun)    n_ov <= n_ov + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == DB + 1) return (^b) ^ parity_odd;
`endif
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    // Present the byte on a tick-aligned cycle with tx_ready high; returns
    // the accept cycle and resumes just after that clock edge.
    task automatic send_byte(input logic [7:0] b, output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk);
            if (tx_ready && (cyc % (BD + 1)) == 0) begin
                tx_data  = b;
                tx_valid = 1'b1;
                t        = cyc;
                got      = 1'b1;
            end
        end
        if (!got) begin
            check_eq("tx_accept_timeout", 32'(got), 1);
        end else begin
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
    endtask

    // Send one byte and check txd over every cycle of the frame.
    task automatic tx_frame_check(input logic [7:0] b);
        int t;
        int ok;
        logic e;
        send_byte(b, t);
        for (int k = 0; k < NB; k++) begin
            ok = 0;
            e  = frame_bit(b, k);
            for (int j = 0; j < BIT_CYC; j++) begin
                @(negedge clk);
                if (txd === e) ok++;
                if (k == NB - 1 && j == BIT_CYC - 2) check_eq("tx_ready_before_end", 32'(tx_ready), 0);
                if (k == NB - 1 && j == BIT_CYC - 1) check_eq("tx_ready_last_cycle", 32'(tx_ready), 1);
            end
            check_eq($sformatf("txd_%02h_bit%0d_cycles", b, k), ok, BIT_CYC);
        end
    endtask

    task automatic wait_tx_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 4000 && !idle; n++) begin
            @(negedge clk);
            idle = tx_ready;
        end
        check_eq("tx_idle_reached", 32'(idle), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = 8'hxx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(rx_valid), 1);
        check_eq({tag, "_data"}, 32'(rx_data), 32'(e));
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    // Bit-bang a frame onto rxd with explicit parity and stop values.
    task automatic bang_frame(input logic [7:0] b, input logic par, input logic stop);
        logic [NB-1:0] bits;
        bits = '0;
        for (int k = 1; k <= DB; k++) bits[k] = b[k-1];
`ifdef UART_PARITY_EN
        bits[DB+1] = par;
`else
        if (par === 1'bx) bits[0] = 1'b0;
`endif
        bits[NB-1] = stop;
        for (int k = 0; k < NB; k++) begin
            rxd_drv = bits[k];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int t0, t1, t2;
    int fe0, pe0, ov0;

    initial begin
        rst_n      = 1'b0;
        baud_div   = 12'(BD);
        parity_odd = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        loop_en    = 1'b1;
        rxd_drv    = 1'b1;

        // reset values
        #12;
        check_eq("rst_txd",        32'(txd), 1);
        check_eq("rst_tx_ready",   32'(tx_ready), 1);
        check_eq("rst_rx_valid",   32'(rx_valid), 0);
        check_eq("rst_rx_count",   32'(rx_count), 0);
        check_eq("rst_rx_data",    32'(rx_data), 0);
        check_eq("rst_frame_err",  32'(frame_err), 0);
        check_eq("rst_parity_err", 32'(parity_err), 0);
        check_eq("rst_overrun",    32'(overrun), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // single frame 0xA5: exact txd waveform, looped back into RX
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        exp_q.push_back(8'hA5);
        tx_frame_check(8'hA5);
        pop_check("a5_rx");

        // back-to-back loopback 0x00, 0xFF, 0x3C
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_byte(8'h00, t0);
        send_byte(8'hFF, t1);
        send_byte(8'h3C, t2);
        check_eq("b2b_gap_1", t1 - t0, NB * BIT_CYC);
        check_eq("b2b_gap_2", t2 - t1, NB * BIT_CYC);
        wait_tx_idle();
        check_eq("b2b_count", 32'(rx_count), 3);
        pop_check("b2b_0");
        pop_check("b2b_1");
        pop_check("b2b_2");
        check_eq("b2b_empty", 32'(rx_valid), 0);
        check_eq("b2b_frame_err", n_fe - fe0, 0);
        check_eq("b2b_parity_err", n_pe - pe0, 0);
        check_eq("b2b_overrun", n_ov - ov0, 0);

        // overrun: five bytes into a four-entry FIFO
        ov0 = n_ov;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'(8'h11 + i));
            send_byte(8'(8'h11 + i), t0);
        end
        wait_tx_idle();
        check_eq("ovr_pulses", n_ov - ov0, 1);
        check_eq("ovr_count", 32'(rx_count), 4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_pop%0d", i));
        check_eq("ovr_empty", 32'(rx_valid), 0);
        check_eq("ovr_count_after", 32'(rx_count), 0);

        // glitch reject: rxd low for 20 cycles only
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        repeat (10) @(negedge clk);
        fe0 = n_fe; pe0 = n_pe;
        rxd_drv = 1'b0;
        repeat (20) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("glitch_count", 32'(rx_count), 0);
        check_eq("glitch_frame_err", n_fe - fe0, 0);
        check_eq("glitch_parity_err", n_pe - pe0, 0);

        // good frame 0x5A then 0x55 with stop bit forced low
        exp_q.push_back(8'h5A);
        bang_frame(8'h5A, (^8'h5A) ^ parity_odd, 1'b1);
        check_eq("good_5a_count", 32'(rx_count), 1);
        fe0 = n_fe;
        bang_frame(8'h55, (^8'h55) ^ parity_odd, 1'b0);
        check_eq("stop0_frame_err", n_fe - fe0, 1);
        check_eq("stop0_count", 32'(rx_count), 1);
        pop_check("good_5a");

`ifdef UART_PARITY_EN
        // even parity: 0x07 needs parity bit 1
        pe0 = n_pe;
        bang_frame(8'h07, 1'b0, 1'b1);
        check_eq("par_bad_err", n_pe - pe0, 1);
        check_eq("par_bad_count", 32'(rx_count), 0);
        exp_q.push_back(8'h07);
        bang_frame(8'h07, 1'b1, 1'b1);
        check_eq("par_good_err", n_pe - pe0, 1);
        pop_check("par_good");
`endif

        // reset during data bit 3 of 0xC3 (bit 3 is 0)
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hC3, t0);
        repeat (4 * BIT_CYC + 20) @(negedge clk);
        check_eq("pre_rst_txd", 32'(txd), 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_txd", 32'(txd), 1);
        check_eq("mid_rst_tx_ready", 32'(tx_ready), 1);
        check_eq("mid_rst_rx_count", 32'(rx_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        exp_q.push_back(8'h3C);
        tx_frame_check(8'h3C);
        pop_check("post_rst_rx");
        check_eq("post_rst_frame_err", n_fe - fe0, 0);
        check_eq("post_rst_overrun", n_ov - ov0, 0);
        check_eq("post_rst_empty", 32'(rx_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
